data_sync_mc: RTL and testbench

DATA_SYNC_MC -- requirements
Module: data_sync_mc

---
 rtl/data_sync_mc.sv | 86 ++++++++
 tb/tb_data_sync_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified bus synchroniser: NUM_STAGES-flop enable chain, edge/toggle detect, one capture register per channel.
// Capture NUM_STAGES edges after first enable sample; a full channel without ready drops the event and sets sticky overflow.
module data_sync_mc #(
    parameter int NUM_STAGES  = 2,
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_CH      = 2,
    parameter int TOGGLE_MODE = 0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic [NUM_CH-1:0]           sync_ready,
    input  logic                        ovf_clr,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]           sync_valid,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic [NUM_CH-1:0]           overflow
);

    logic [NUM_CH-1:0][NUM_STAGES-1:0] chain_q, chain_d;
    logic [NUM_CH-1:0]                 edge_q, edge_d;
    logic [NUM_CH*BUS_WIDTH-1:0]       bus_q, bus_d;
    logic [NUM_CH-1:0]                 valid_q, valid_d;
    logic [NUM_CH-1:0]                 pulse_q, pulse_d;
    logic [NUM_CH-1:0]                 ovf_q, ovf_d;
    logic [NUM_CH-1:0]                 chain_out, evt, cap_ok;

    always_comb begin
        chain_out = '0;
        evt       = '0;
        cap_ok    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            chain_out[c] = chain_q[c][NUM_STAGES-1];
            evt[c]       = (TOGGLE_MODE != 0) ? (chain_out[c] ^ edge_q[c])
                                              : (chain_out[c] & ~edge_q[c]);
            // A held word may be replaced in the same cycle the consumer takes it.
            cap_ok[c]    = ~valid_q[c] | sync_ready[c];
        end
    end

    always_comb begin
        chain_d = chain_q;
        edge_d  = chain_out;
        bus_d   = bus_q;
        valid_d = valid_q;
        pulse_d = '0;
        ovf_d   = ovf_q & {NUM_CH{~ovf_clr}};
        for (int c = 0; c < NUM_CH; c++) begin
            chain_d[c] = {chain_q[c][NUM_STAGES-2:0], bus_enable[c]};
            if (evt[c] && cap_ok[c]) begin
                bus_d[c*BUS_WIDTH +: BUS_WIDTH] = unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
                valid_d[c] = 1'b1;
                pulse_d[c] = 1'b1;
            end else if (evt[c]) begin
                ovf_d[c] = 1'b1;
            end else if (valid_q[c] && sync_ready[c]) begin
                valid_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain_q <= '0;
            edge_q  <= '0;
            bus_q   <= '0;
            valid_q <= '0;
            pulse_q <= '0;
            ovf_q   <= '0;
        end else begin
            chain_q <= chain_d;
            edge_q  <= edge_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
            pulse_q <= pulse_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sync_bus     = bus_q;
    assign sync_valid   = valid_q;
    assign enable_pulse = pulse_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_data_sync_mc.sv
// Bench for data_sync_mc: a level-mode and a toggle-mode instance, directed scenarios plus random traffic vs a reference model.
module tb_data_sync_mc;
    localparam int S  = 2;
    localparam int BW = 8;
    localparam int NC = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              ovf_clr;
    logic [NC*BW-1:0]  din  [2];
    logic [NC-1:0]     en   [2];
    logic [NC-1:0]     rdy  [2];
    logic [NC*BW-1:0]  sbus [2];
    logic [NC-1:0]     svld [2];
    logic [NC-1:0]     spls [2];
    logic [NC-1:0]     sovf [2];

    int checks   = 0;
    int failures = 0;

    data_sync_mc #(.NUM_STAGES(S), .BUS_WIDTH(BW), .NUM_CH(NC), .TOGGLE_MODE(0)) dut0 (
        .CLK(CLK), .RST(RST), .unsync_bus(din[0]), .bus_enable(en[0]), .sync_ready(rdy[0]),
        .ovf_clr(ovf_clr), .sync_bus(sbus[0]), .sync_valid(svld[0]), .enable_pulse(spls[0]),
        .overflow(sovf[0]));

    data_sync_mc #(.NUM_STAGES(S), .BUS_WIDTH(BW), .NUM_CH(NC), .TOGGLE_MODE(1)) dut1 (
        .CLK(CLK), .RST(RST), .unsync_bus(din[1]), .bus_enable(en[1]), .sync_ready(rdy[1]),
        .ovf_clr(ovf_clr), .sync_bus(sbus[1]), .sync_valid(svld[1]), .enable_pulse(spls[1]),
        .overflow(sovf[1]));

    always #5 CLK = ~CLK;

    // Reference: an event is seen at edge n when the enable sample from edge n-S
    // differs from (toggle) or rises over (level) the sample from edge n-S-1.
    bit             m_hist [2][NC][S+1];
    logic [BW-1:0]  m_bus  [2][NC];
    bit             m_vld  [2][NC];
    bit             m_pls  [2][NC];
    bit             m_ovf  [2][NC];

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < NC; c++) begin
                    for (int i = 0; i <= S; i++) m_hist[d][c][i] = 0;
                    m_bus[d][c] = '0;
                    m_vld[d][c] = 0;
                    m_pls[d][c] = 0;
                    m_ovf[d][c] = 0;
                end
        end else begin
            for (int d = 0; d < 2; d++)
                for (int c = 0; c < NC; c++) begin
                    bit newer, older, ev, ok, nxt_ovf;
                    newer   = m_hist[d][c][S-1];
                    older   = m_hist[d][c][S];
                    ev      = (d == 0) ? (newer && !older) : (newer != older);
                    ok      = !m_vld[d][c] || rdy[d][c];
                    nxt_ovf = (m_ovf[d][c] && !ovf_clr) || (ev && !ok);
                    m_pls[d][c] = ev && ok;
                    if (ev && ok) begin
                        m_bus[d][c] = din[d][c*BW +: BW];
                        m_vld[d][c] = 1;
                    end else if (!ev && m_vld[d][c] && rdy[d][c]) begin
                        m_vld[d][c] = 0;
                    end
                    m_ovf[d][c] = nxt_ovf;
                    for (int i = S; i > 0; i--) m_hist[d][c][i] = m_hist[d][c][i-1];
                    m_hist[d][c][0] = en[d][c];
                end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ovf_clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            din[d] = '0;
            en[d]  = '0;
            rdy[d] = '0;
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        clear_inputs();
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        clear_inputs();
        #3;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({sbus[d], svld[d], spls[d], sovf[d]} !== '0) begin
                failures++;
                $display("FAIL reset_state d%0d got bus=%h v=%b p=%b o=%b need all 0",
                         d, sbus[d], svld[d], spls[d], sovf[d]);
            end
        end
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic test_capture();
        int pulses = 0;
        din[0][7:0] = 8'hA5;
        en[0][0]    = 1'b1;
        tick();
        tick();
        checks++;
        if (spls[0][0] !== 1'b0) begin
            failures++;
            $display("FAIL early_pulse got %b need 0", spls[0][0]);
        end
        tick();
        checks++;
        if (spls[0][0] !== 1'b1 || sbus[0][7:0] !== 8'hA5 || svld[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL capture got p=%b bus=%h v=%b need p=1 bus=a5 v=1",
                     spls[0][0], sbus[0][7:0], svld[0][0]);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (spls[0][0] === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL held_level pulses=%0d need 0", pulses);
        end
    endtask

    task automatic test_overflow();
        en[0][0] = 1'b0;
        tick();
        tick();
        tick();
        din[0][7:0] = 8'h3C;
        en[0][0]    = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (sbus[0][7:0] !== 8'hA5 || sovf[0][0] !== 1'b1 || spls[0][0] !== 1'b0 || svld[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL overflow got bus=%h o=%b p=%b v=%b need bus=a5 o=1 p=0 v=1",
                     sbus[0][7:0], sovf[0][0], spls[0][0], svld[0][0]);
        end
        en[0][0] = 1'b0;
        ovf_clr  = 1'b1;
        tick();
        ovf_clr  = 1'b0;
        checks++;
        if (sovf[0][0] !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr got %b need 0", sovf[0][0]);
        end
    endtask

    task automatic test_ready_same_cycle();
        tick();
        tick();
        tick();
        din[0][7:0] = 8'h77;
        en[0][0]    = 1'b1;
        tick();
        tick();
        rdy[0][0] = 1'b1;
        tick();
        rdy[0][0] = 1'b0;
        checks++;
        if (sbus[0][7:0] !== 8'h77 || svld[0][0] !== 1'b1 || sovf[0][0] !== 1'b0 || spls[0][0] !== 1'b1) begin
            failures++;
            $display("FAIL ready_same got bus=%h v=%b o=%b p=%b need bus=77 v=1 o=0 p=1",
                     sbus[0][7:0], svld[0][0], sovf[0][0], spls[0][0]);
        end
        en[0][0] = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        din[0] = 16'h0201;
        en[0]  = 2'b11;
        tick();
        tick();
        tick();
        checks++;
        if (spls[0] !== 2'b11 || sbus[0] !== 16'h0201 || svld[0] !== 2'b11) begin
            failures++;
            $display("FAIL simultaneous got p=%b bus=%h v=%b need p=11 bus=0201 v=11",
                     spls[0], sbus[0], svld[0]);
        end
    endtask

    task automatic test_toggle();
        int pulses = 0;
        logic [BW-1:0] cap = '0;
        do_reset();
        rdy[1]        = 2'b11;
        din[1][15:8]  = 8'h11;
        en[1][1]      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (spls[1][1] === 1'b1) begin
                pulses++;
                cap = sbus[1][15:8];
            end
        end
        checks++;
        if (pulses != 1 || cap !== 8'h11) begin
            failures++;
            $display("FAIL toggle_rise pulses=%0d data=%h need 1 pulse data=11", pulses, cap);
        end
        pulses       = 0;
        din[1][15:8] = 8'h22;
        en[1][1]     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (spls[1][1] === 1'b1) begin
                pulses++;
                cap = sbus[1][15:8];
            end
        end
        checks++;
        if (pulses != 1 || cap !== 8'h22) begin
            failures++;
            $display("FAIL toggle_fall pulses=%0d data=%h need 1 pulse data=22", pulses, cap);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset();
        din[0][7:0] = 8'h5A;
        en[0][0]    = 1'b1;
        tick();
        tick();
        RST      = 1'b0;
        en[0][0] = 1'b0;
        #2;
        checks++;
        if ({sbus[0], svld[0], spls[0], sovf[0]} !== '0) begin
            failures++;
            $display("FAIL reset_mid_clear got bus=%h v=%b p=%b o=%b need all 0",
                     sbus[0], svld[0], spls[0], sovf[0]);
        end
        tick();
        RST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (spls[0][0] === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || svld[0][0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_discard pulses=%0d v=%b need 0 pulses v=0", pulses, svld[0][0]);
        end
    endtask

    task automatic test_release_high();
        RST = 1'b0;
        clear_inputs();
        en[0][0] = 1'b1;
        en[1][0] = 1'b1;
        tick();
        RST = 1'b1;
        tick();
        tick();
        checks++;
        if (spls[0][0] !== 1'b0 || spls[1][0] !== 1'b0) begin
            failures++;
            $display("FAIL release_early got p0=%b p1=%b need 0 0", spls[0][0], spls[1][0]);
        end
        tick();
        checks++;
        if (spls[0][0] !== 1'b1 || spls[1][0] !== 1'b1) begin
            failures++;
            $display("FAIL release_high got p0=%b p1=%b need 1 1", spls[0][0], spls[1][0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            ovf_clr = ($urandom_range(7) == 0);
            for (int d = 0; d < 2; d++) begin
                din[d] = NC*BW'($urandom);
                rdy[d] = NC'($urandom);
                for (int c = 0; c < NC; c++)
                    if ($urandom_range(3) == 0) en[d][c] = ~en[d][c];
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                logic [NC*BW-1:0] eb;
                logic [NC-1:0]    ev, ep, eo;
                for (int c = 0; c < NC; c++) begin
                    eb[c*BW +: BW] = m_bus[d][c];
                    ev[c] = m_vld[d][c];
                    ep[c] = m_pls[d][c];
                    eo[c] = m_ovf[d][c];
                end
                checks++;
                if ({sbus[d], svld[d], spls[d], sovf[d]} !== {eb, ev, ep, eo}) begin
                    failures++;
                    $display("FAIL random d%0d cyc%0d got bus=%h v=%b p=%b o=%b need bus=%h v=%b p=%b o=%b",
                             d, cyc, sbus[d], svld[d], spls[d], sovf[d], eb, ev, ep, eo);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_capture();
        test_overflow();
        test_ready_same_cycle();
        test_simultaneous();
        test_toggle();
        test_reset_mid();
        test_release_high();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
